// File: rtl/hwpe_ctrl_context_sched_if.sv
// Handshake/status bundle between the context scheduler, its cores-facing register
// file and the engine; slave is the scheduler side, master the driving side.
interface hwpe_ctrl_context_sched_if #(
    parameter int N_CONTEXT = 2,
    parameter int ID_WIDTH  = 16,
    localparam int CW       = (N_CONTEXT > 1) ? $clog2(N_CONTEXT) : 1
);
    logic                 clear_i;
    logic                 acquire_i;
    logic [ID_WIDTH-1:0]  acquire_src_i;
    logic                 trigger_i;
    logic                 done_i;
    logic                 resp_valid_o;
    logic [31:0]          resp_data_o;
    logic                 start_o;
    logic                 true_done_o;
    logic [CW-1:0]        pointer_context_o;
    logic [CW-1:0]        running_context_o;
    logic                 full_context_o;
    logic                 is_critical_o;
    logic [ID_WIDTH-1:0]  owner_o;
    logic [N_CONTEXT-1:0] ctx_busy_o;
    logic                 busy_o;

    modport slave (
        input  clear_i, acquire_i, acquire_src_i, trigger_i, done_i,
        output resp_valid_o, resp_data_o, start_o, true_done_o, pointer_context_o,
               running_context_o, full_context_o, is_critical_o, owner_o, ctx_busy_o, busy_o
    );

    modport master (
        output clear_i, acquire_i, acquire_src_i, trigger_i, done_i,
        input  resp_valid_o, resp_data_o, start_o, true_done_o, pointer_context_o,
               running_context_o, full_context_o, is_critical_o, owner_o, ctx_busy_o, busy_o
    );
endinterface

// File: rtl/hwpe_ctrl_context_sched.sv
// Ring-of-contexts job scheduler: test-and-set acquire, trigger-to-ready, engine start/done.
// Acquire response one cycle after the request; trigger to start_o is two cycles when idle.
module hwpe_ctrl_context_sched #(
    parameter int N_CONTEXT = 2,
    parameter int ID_WIDTH  = 16
) (
    input logic                   clk_i,
    input logic                   rst_ni,
    hwpe_ctrl_context_sched_if.slave sched
);
    localparam int CW  = (N_CONTEXT > 1) ? $clog2(N_CONTEXT) : 1;
    localparam int NBW = $clog2(N_CONTEXT + 1);
    localparam logic [CW-1:0]  LAST_CTX = CW'(N_CONTEXT - 1);
    localparam logic [NBW-1:0] N_FULL   = NBW'(N_CONTEXT);

    typedef enum logic [1:0] {IDLE, START, RUN} state_t;

    state_t               r_state, w_state_nxt;
    logic [N_CONTEXT-1:0] r_ctx_ready, w_ctx_ready_nxt;
    logic [N_CONTEXT-1:0] r_ctx_busy, w_ctx_busy_nxt;
    logic [NBW-1:0]       r_n_busy, w_n_busy_nxt;
    logic [7:0]           r_job_id;
    logic [CW-1:0]        r_pointer, r_running;
    logic                 r_critical, r_full, r_true_done, r_resp_valid;
    logic [ID_WIDTH-1:0]  r_owner;
    logic [31:0]          r_resp_data, w_resp_word;
    logic                 w_start, w_done_evt, w_grant, w_trig;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)            r_state <= IDLE;
        else if (sched.clear_i) r_state <= IDLE;
        else                    r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_done_evt  = 1'b0;
        case (r_state)
            IDLE:  if (r_ctx_ready[r_running]) w_state_nxt = START;
            START: begin
                w_start     = 1'b1;
                w_state_nxt = RUN;
            end
            RUN:   if (sched.done_i) begin
                w_done_evt  = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Flags are registered, so same-cycle trigger/done are not seen by an acquire.
    assign w_grant = sched.acquire_i && !r_critical && !r_full;
    assign w_trig  = sched.trigger_i && r_critical;

    always_comb begin
        w_ctx_ready_nxt = r_ctx_ready;
        w_ctx_busy_nxt  = r_ctx_busy;
        w_n_busy_nxt    = r_n_busy;
        if (w_start)    w_ctx_ready_nxt[r_running] = 1'b0;
        if (w_trig)     w_ctx_ready_nxt[r_pointer] = 1'b1;
        if (w_done_evt) w_ctx_busy_nxt[r_running]  = 1'b0;
        if (w_grant)    w_ctx_busy_nxt[r_pointer]  = 1'b1;
        if (w_grant && !w_done_evt)      w_n_busy_nxt = r_n_busy + 1'b1;
        else if (!w_grant && w_done_evt) w_n_busy_nxt = r_n_busy - 1'b1;
    end

    always_comb begin
        if (r_critical)  w_resp_word = 32'hFFFF_FFFE;
        else if (r_full) w_resp_word = 32'hFFFF_FFFF;
        else             w_resp_word = {24'b0, r_job_id};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni || sched.clear_i) begin
            r_ctx_ready  <= '0;
            r_ctx_busy   <= '0;
            r_n_busy     <= '0;
            r_job_id     <= '0;
            r_pointer    <= '0;
            r_running    <= '0;
            r_critical   <= 1'b0;
            r_full       <= 1'b0;
            r_true_done  <= 1'b0;
            r_resp_valid <= 1'b0;
            r_owner      <= '0;
            r_resp_data  <= '0;
        end else begin
            r_ctx_ready  <= w_ctx_ready_nxt;
            r_ctx_busy   <= w_ctx_busy_nxt;
            r_n_busy     <= w_n_busy_nxt;
            r_full       <= (w_n_busy_nxt == N_FULL);
            r_true_done  <= w_done_evt;
            r_resp_valid <= sched.acquire_i;
            if (sched.acquire_i) r_resp_data <= w_resp_word;
            if (w_grant) begin
                r_job_id   <= r_job_id + 8'd1;
                r_critical <= 1'b1;
                r_owner    <= sched.acquire_src_i;
            end else if (w_trig) begin
                r_critical <= 1'b0;
            end
            if (w_trig)     r_pointer <= (r_pointer == LAST_CTX) ? '0 : r_pointer + 1'b1;
            if (w_done_evt) r_running <= (r_running == LAST_CTX) ? '0 : r_running + 1'b1;
        end
    end

    assign sched.resp_valid_o      = r_resp_valid;
    assign sched.resp_data_o       = r_resp_data;
    assign sched.start_o           = w_start;
    assign sched.true_done_o       = r_true_done;
    assign sched.pointer_context_o = r_pointer;
    assign sched.running_context_o = r_running;
    assign sched.full_context_o    = r_full;
    assign sched.is_critical_o     = r_critical;
    assign sched.owner_o           = r_owner;
    assign sched.ctx_busy_o        = r_ctx_busy;
    assign sched.busy_o            = (r_state != IDLE);
endmodule

// File: tb/tb_hwpe_ctrl_context_sched.sv
// Directed bench: expected acquire responses and start/true_done cycles are queued at
// stimulus time and popped by independent monitors when the DUT presents them.
module tb_hwpe_ctrl_context_sched;
    logic clk_i = 1'b0;
    logic rst_ni;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;

    logic [31:0] resp_q[$];
    int          start_q[$];
    int          done_q[$];

    hwpe_ctrl_context_sched_if #(.N_CONTEXT(2), .ID_WIDTH(16)) sif ();

    hwpe_ctrl_context_sched #(.N_CONTEXT(2), .ID_WIDTH(16)) dut (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .sched (sif)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitors sample on the falling edge, away from the active edge.
    always @(negedge clk_i) begin
        if (rst_ni && sif.resp_valid_o) begin
            if (resp_q.size() == 0) chk("resp_unexpected", sif.resp_data_o, 32'hDEAD_BEEF);
            else chk("resp_data", sif.resp_data_o, resp_q.pop_front());
        end
        if (rst_ni && sif.start_o) begin
            if (start_q.size() == 0) chk("start_unexpected", 32'(cyc), 32'hFFFF_FFFF);
            else chk("start_cycle", 32'(cyc), 32'(start_q.pop_front()));
        end
        if (rst_ni && sif.true_done_o) begin
            if (done_q.size() == 0) chk("true_done_unexpected", 32'(cyc), 32'hFFFF_FFFF);
            else chk("true_done_cycle", 32'(cyc), 32'(done_q.pop_front()));
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic acq(input logic [15:0] src, input logic [31:0] exp);
        sif.acquire_i     = 1'b1;
        sif.acquire_src_i = src;
        resp_q.push_back(exp);
        tick();
        sif.acquire_i = 1'b0;
    endtask

    task automatic trig(input bit exp_start);
        sif.trigger_i = 1'b1;
        if (exp_start) start_q.push_back(cyc + 2);
        tick();
        sif.trigger_i = 1'b0;
    endtask

    task automatic done_p(input bit exp_td, input bit exp_start);
        sif.done_i = 1'b1;
        if (exp_td) done_q.push_back(cyc + 1);
        if (exp_start) start_q.push_back(cyc + 2);
        tick();
        sif.done_i = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_resp_valid"}, 32'(sif.resp_valid_o), 32'd0);
        chk({tag, "_resp_data"}, sif.resp_data_o, 32'd0);
        chk({tag, "_start"}, 32'(sif.start_o), 32'd0);
        chk({tag, "_true_done"}, 32'(sif.true_done_o), 32'd0);
        chk({tag, "_pointer"}, 32'(sif.pointer_context_o), 32'd0);
        chk({tag, "_running"}, 32'(sif.running_context_o), 32'd0);
        chk({tag, "_full"}, 32'(sif.full_context_o), 32'd0);
        chk({tag, "_critical"}, 32'(sif.is_critical_o), 32'd0);
        chk({tag, "_owner"}, 32'(sif.owner_o), 32'd0);
        chk({tag, "_ctx_busy"}, 32'(sif.ctx_busy_o), 32'd0);
        chk({tag, "_busy"}, 32'(sif.busy_o), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d want < 40000", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni            = 1'b0;
        sif.clear_i       = 1'b0;
        sif.acquire_i     = 1'b0;
        sif.acquire_src_i = '0;
        sif.trigger_i     = 1'b0;
        sif.done_i        = 1'b0;
        repeat (2) tick();
        chk_all_zero("rst");
        rst_ni = 1'b1;
        tick();

        // First grant, then a refused acquire while critical
        acq(16'd3, 32'd0);
        chk("g0_resp_valid", 32'(sif.resp_valid_o), 32'd1);
        chk("g0_critical", 32'(sif.is_critical_o), 32'd1);
        chk("g0_owner", 32'(sif.owner_o), 32'd3);
        chk("g0_ctx_busy", 32'(sif.ctx_busy_o), 32'b01);
        chk("g0_full", 32'(sif.full_context_o), 32'd0);
        acq(16'd5, 32'hFFFF_FFFE);
        chk("crit_owner", 32'(sif.owner_o), 32'd3);
        chk("crit_critical", 32'(sif.is_critical_o), 32'd1);
        tick();
        chk("hold_resp_valid", 32'(sif.resp_valid_o), 32'd0);
        chk("hold_resp_data", sif.resp_data_o, 32'hFFFF_FFFE);

        // Trigger -> start two cycles later -> done
        trig(1'b1);
        chk("trig_pointer", 32'(sif.pointer_context_o), 32'd1);
        chk("trig_critical", 32'(sif.is_critical_o), 32'd0);
        chk("trig_no_early_start", 32'(sif.start_o), 32'd0);
        tick();
        chk("start_busy", 32'(sif.busy_o), 32'd1);
        tick();
        chk("start_single", 32'(sif.start_o), 32'd0);
        chk("run_busy", 32'(sif.busy_o), 32'd1);
        done_p(1'b1, 1'b0);
        chk("done_true_done", 32'(sif.true_done_o), 32'd1);
        chk("done_running", 32'(sif.running_context_o), 32'd1);
        chk("done_ctx_busy", 32'(sif.ctx_busy_o), 32'b00);
        chk("done_busy", 32'(sif.busy_o), 32'd0);
        tick();
        chk("true_done_single", 32'(sif.true_done_o), 32'd0);

        // Fill both contexts, refuse when full, free one, grant again
        acq(16'd7, 32'd1);
        trig(1'b1);
        acq(16'd9, 32'd2);
        trig(1'b0);
        chk("fill_full", 32'(sif.full_context_o), 32'd1);
        chk("fill_ctx_busy", 32'(sif.ctx_busy_o), 32'b11);
        acq(16'd11, 32'hFFFF_FFFF);
        done_p(1'b1, 1'b1);
        chk("free_full", 32'(sif.full_context_o), 32'd0);
        chk("free_running", 32'(sif.running_context_o), 32'd0);
        acq(16'd13, 32'd3);
        chk("regrant_full", 32'(sif.full_context_o), 32'd1);
        chk("regrant_owner", 32'(sif.owner_o), 32'd13);
        trig(1'b0);
        done_p(1'b1, 1'b1);
        chk("b2b_running", 32'(sif.running_context_o), 32'd1);
        repeat (2) tick();
        done_p(1'b1, 1'b0);
        chk("drain_running", 32'(sif.running_context_o), 32'd0);
        chk("drain_ctx_busy", 32'(sif.ctx_busy_o), 32'd0);
        chk("drain_full", 32'(sif.full_context_o), 32'd0);

        // Spurious done and trigger are ignored
        done_p(1'b0, 1'b0);
        trig(1'b0);
        tick();
        chk("spur_pointer", 32'(sif.pointer_context_o), 32'd0);
        chk("spur_running", 32'(sif.running_context_o), 32'd0);
        chk("spur_critical", 32'(sif.is_critical_o), 32'd0);
        chk("spur_ctx_busy", 32'(sif.ctx_busy_o), 32'd0);
        chk("spur_busy", 32'(sif.busy_o), 32'd0);
        chk("spur_full", 32'(sif.full_context_o), 32'd0);

        // Job ID wrap: ids 4..255 then 0 on the 257th grant
        for (int i = 0; i < 252; i++) begin
            acq(16'(i), 32'((4 + i) & 255));
            trig(1'b1);
            repeat (2) tick();
            done_p(1'b1, 1'b0);
        end
        acq(16'd30, 32'd0);
        chk("wrap_critical", 32'(sif.is_critical_o), 32'd1);

        // Acquire together with trigger sees the old critical flag
        sif.acquire_i     = 1'b1;
        sif.acquire_src_i = 16'd31;
        sif.trigger_i     = 1'b1;
        resp_q.push_back(32'hFFFF_FFFE);
        start_q.push_back(cyc + 2);
        tick();
        sif.acquire_i = 1'b0;
        sif.trigger_i = 1'b0;
        chk("acqtrig_critical", 32'(sif.is_critical_o), 32'd0);
        chk("acqtrig_owner", 32'(sif.owner_o), 32'd30);
        repeat (2) tick();
        chk("pre_clear_busy", 32'(sif.busy_o), 32'd1);

        // Soft clear in RUN
        sif.clear_i = 1'b1;
        tick();
        sif.clear_i = 1'b0;
        chk_all_zero("clr");
        repeat (6) tick();
        chk("post_clear_busy", 32'(sif.busy_o), 32'd0);
        acq(16'd40, 32'd0);
        chk("post_clear_ctx_busy", 32'(sif.ctx_busy_o), 32'b01);
        tick();

        chk("resp_q_drained", 32'(resp_q.size()), 32'd0);
        chk("start_q_drained", 32'(start_q.size()), 32'd0);
        chk("done_q_drained", 32'(done_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
